// File: rtl/amiga_kbd_serial_tx.sv
// Amiga keyboard-side serial transmitter.
// Takes key events from the HID FIFO and shifts each one out on KCLK/KDAT using
// keyboard timing. After each byte it waits for the CIA to pulse KDAT low as a
// handshake. If no handshake arrives in time it clocks out resync bits, then sends
// the lost-sync code followed by the byte that went unacknowledged. After reset it
// can also send the power-up codes.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_INIT    | after reset with POWERUP=1, start the 0xFD/0xFE sequence
// S_IDLE    | lines high, waiting for keystrobe
// S_SEND    | shifting 8 bits, each bit is SETUP / CLK_LO / CLK_HI
// S_WAIT_HS | kdat released, waiting for the CIA low pulse or a timeout
// S_RESYNC  | one clock with kdat low, then back to S_WAIT_HS
module amiga_kbd_serial_tx #(
  parameter int BIT_PHASE  = 142,
  parameter int HS_MIN     = 7,
  parameter int HS_TIMEOUT = 1014000,
  parameter int POWERUP    = 1
) (
  input  logic       clk7,
  input  logic       reset,
  input  logic       keystrobe,
  input  logic [7:0] keydat,
  output logic       keyack,
  output logic       busy,
  output logic       kclk,
  output logic       kdat,
  input  logic       kdat_in
);

  localparam int RUN_W = (HS_MIN < 1) ? 1 : $clog2(HS_MIN + 1);
  localparam logic [7:0]  PH_END  = 8'(BIT_PHASE - 1);
  localparam logic [19:0] TMO_END = 20'(HS_TIMEOUT - 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SEND, S_WAIT_HS, S_RESYNC} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_CLK_LO, PH_CLK_HI} sub_t;
  typedef enum logic [1:0] {B_FD, B_FE, B_F9, B_LAST} sel_t;

  // Line order: code bits 6..0, then bit 7. Each bit is inverted because the line is active low.
  function automatic logic [7:0] encode(input logic [7:0] c);
    encode = ~{c[6:0], c[7]};
  endfunction

  localparam logic [7:0] TX_FD = encode(8'hFD);
  localparam logic [7:0] TX_FE = encode(8'hFE);
  localparam logic [7:0] TX_F9 = encode(8'hF9);

  state_t           state;
  sub_t             sub;
  sel_t             cur;
  sel_t             pend;
  logic [7:0]       phase;
  logic [19:0]      tmo;
  logic [2:0]       bit_idx;
  logic [6:0]       shift;
  logic [7:0]       last;
  logic             resync_pend;
  logic             sync1, sync2, sync3;
  logic             armed;
  logic [RUN_W-1:0] run;
  logic             hs_event;
  logic             last_bit;
  logic [7:0]       tx_key;
  logic [7:0]       tx_last;
  logic [7:0]       tx_pend;
  logic             load_en;
  sel_t             load_sel;
  logic [7:0]       load_word;

  assign tx_key  = encode(keydat);
  assign tx_last = encode(last);

  // A handshake is a synced rising edge that ends a low run of at least HS_MIN cycles.
  assign hs_event = (state == S_WAIT_HS) && armed && sync2 && !sync3 &&
                    (run >= RUN_W'(HS_MIN));

  // A resync frame is one bit long. A data frame ends after bit 7.
  assign last_bit = (state == S_RESYNC) || (bit_idx == 3'd7);

  // Select the byte to resend after the lost-sync code.
  always_comb begin
    tx_pend = tx_last;
    case (pend)
      B_FD:    tx_pend = TX_FD;
      B_FE:    tx_pend = TX_FE;
      B_F9:    tx_pend = TX_F9;
      default: tx_pend = tx_last;
    endcase
  end

  // Decide whether a new byte starts this cycle, and which byte it is.
  always_comb begin
    load_en   = 1'b0;
    load_sel  = B_LAST;
    load_word = tx_key;
    case (state)
      S_INIT: begin
        load_en   = 1'b1;
        load_sel  = B_FD;
        load_word = TX_FD;
      end
      S_IDLE: begin
        if (keystrobe) begin
          load_en   = 1'b1;
          load_sel  = B_LAST;
          load_word = tx_key;
        end
      end
      S_WAIT_HS: begin
        if (hs_event) begin
          if (resync_pend) begin
            load_en   = 1'b1;
            load_sel  = B_F9;
            load_word = TX_F9;
          end else if (cur == B_FD) begin
            load_en   = 1'b1;
            load_sel  = B_FE;
            load_word = TX_FE;
          end else if (cur == B_F9) begin
            load_en   = 1'b1;
            load_sel  = pend;
            load_word = tx_pend;
          end
        end
      end
      default: ;
    endcase
  end

  // Two-flop synchroniser on the resolved KDAT line, plus a delayed copy for edge detection.
  always_ff @(posedge clk7) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= kdat_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Main sequencer: bit timing, handshake wait, timeout and resync recovery.
  always_ff @(posedge clk7) begin
    if (reset) begin
      state       <= (POWERUP != 0) ? S_INIT : S_IDLE;
      sub         <= PH_SETUP;
      cur         <= B_LAST;
      pend        <= B_LAST;
      phase       <= 8'd0;
      tmo         <= 20'd0;
      bit_idx     <= 3'd0;
      shift       <= 7'd0;
      last        <= 8'h00;
      resync_pend <= 1'b0;
      armed       <= 1'b0;
      run         <= '0;
      keyack      <= 1'b0;
      busy        <= 1'b0;
      kclk        <= 1'b1;
      kdat        <= 1'b1;
    end else begin
      keyack <= 1'b0;
      if (load_en) begin
        state       <= S_SEND;
        sub         <= PH_SETUP;
        cur         <= load_sel;
        phase       <= 8'd0;
        tmo         <= 20'd0;
        bit_idx     <= 3'd0;
        shift       <= load_word[6:0];
        kdat        <= load_word[7];
        kclk        <= 1'b1;
        busy        <= 1'b1;
        resync_pend <= 1'b0;
        if (state == S_IDLE) last <= keydat;
      end else begin
        case (state)
          S_SEND, S_RESYNC: begin
            if (phase == PH_END) begin
              phase <= 8'd0;
              case (sub)
                PH_SETUP: begin
                  sub  <= PH_CLK_LO;
                  kclk <= 1'b0;
                end
                PH_CLK_LO: begin
                  sub  <= PH_CLK_HI;
                  kclk <= 1'b1;
                end
                default: begin
                  sub <= PH_SETUP;
                  if (last_bit) begin
                    state   <= S_WAIT_HS;
                    kdat    <= 1'b1;
                    tmo     <= 20'd0;
                    bit_idx <= 3'd0;
                    armed   <= 1'b0;
                    run     <= '0;
                  end else begin
                    bit_idx <= bit_idx + 3'd1;
                    kdat    <= shift[6];
                    shift   <= {shift[5:0], 1'b0};
                  end
                end
              endcase
            end else begin
              phase <= phase + 8'd1;
            end
          end
          S_WAIT_HS: begin
            if (hs_event) begin
              // Only a user byte or the final power-up code gets here. Internal bytes
              // that continue a sequence are started through the load path.
              state <= S_IDLE;
              busy  <= 1'b0;
              if (cur == B_LAST) keyack <= 1'b1;
            end else if (tmo == TMO_END) begin
              state       <= S_RESYNC;
              sub         <= PH_SETUP;
              phase       <= 8'd0;
              tmo         <= 20'd0;
              kdat        <= 1'b0;
              kclk        <= 1'b1;
              resync_pend <= 1'b1;
              if (cur != B_F9) pend <= cur;
            end else begin
              tmo <= tmo + 20'd1;
              // The released line must be seen high before a low run counts. This keeps
              // the tail of a 0 data bit, still passing through the synchroniser, from
              // being taken as a handshake.
              if (sync2) begin
                armed <= 1'b1;
                run   <= '0;
              end else if (armed && (run < RUN_W'(HS_MIN))) begin
                run <= run + RUN_W'(1);
              end
            end
          end
          S_IDLE: ;
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_amiga_kbd_serial_tx.sv
// Self-checking bench for amiga_kbd_serial_tx. The bench models the CIA side:
// it collects the KDAT level at each KCLK fall and drives handshake pulses on
// a wired-AND KDAT line.
module tb_amiga_kbd_serial_tx;

  localparam int BP  = 4;
  localparam int HSM = 2;
  localparam int HTO = 200;
  // Time from one KCLK fall to the next: CLK_LO + CLK_HI + timeout + SETUP.
  localparam int RESYNC_GAP = 2 * BP + HTO + BP;

  logic       clk7 = 1'b0;
  logic       reset;
  logic       keystrobe;
  logic [7:0] keydat;
  logic       keyack;
  logic       busy;
  logic       kclk;
  logic       kdat;
  logic       cia;
  logic       kdat_in;

  assign kdat_in = kdat & cia;

  amiga_kbd_serial_tx #(
    .BIT_PHASE (BP),
    .HS_MIN    (HSM),
    .HS_TIMEOUT(HTO),
    .POWERUP   (1)
  ) dut (
    .clk7     (clk7),
    .reset    (reset),
    .keystrobe(keystrobe),
    .keydat   (keydat),
    .keyack   (keyack),
    .busy     (busy),
    .kclk     (kclk),
    .kdat     (kdat),
    .kdat_in  (kdat_in)
  );

  always #5 clk7 = ~clk7;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acks = 0;
  logic ack_wide = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_kclk = 1'b1;
  int   last_fall_cyc = 0;
  bit   falls[$];
  int   fall_cyc[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: the line carries code bits 6..0 and then bit 7, each inverted. The first level is the MSB.
  function automatic logic [7:0] line_levels(input logic [7:0] code);
    logic [7:0] lv;
    for (int i = 0; i < 8; i++) begin
      int src;
      src = (i < 7) ? (6 - i) : 7;
      lv[7 - i] = !code[src];
    end
    return lv;
  endfunction

  // CIA-side observer: records the level at each KCLK fall and counts keyack pulses.
  always @(negedge clk7) begin
    cyc       <= cyc + 1;
    prev_kclk <= kclk;
    prev_ack  <= keyack;
    if (prev_kclk === 1'b1 && kclk === 1'b0) begin
      falls.push_back(kdat);
      fall_cyc.push_back(cyc);
    end
    if (keyack === 1'b1) acks <= acks + 1;
    if (keyack === 1'b1 && prev_ack === 1'b1) ack_wide <= 1'b1;
  end

  task automatic flush();
    falls.delete();
    fall_cyc.delete();
  endtask

  task automatic send_key(input logic [7:0] code);
    @(posedge clk7); #1;
    keystrobe = 1'b1;
    keydat    = code;
    @(posedge clk7); #1;
    keystrobe = 1'b0;
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] code);
    int n = 0;
    logic [7:0] got = 8'h00;
    int c0 = 0;
    int c = 0;
    while (falls.size() < 8 && n < 400) begin
      @(posedge clk7);
      n++;
    end
    if (falls.size() < 8) begin
      chk({tag, "_tmo"}, falls.size(), 8);
      flush();
      return;
    end
    for (int i = 0; i < 8; i++) begin
      got = {got[6:0], falls.pop_front()};
      c   = fall_cyc.pop_front();
      if (i == 0) c0 = c;
    end
    last_fall_cyc = c;
    chk(tag, got, line_levels(code));
    chk({tag, "_span"}, c - c0, 7 * 3 * BP);
  endtask

  task automatic recv_resync(input string tag);
    int n = 0;
    bit lv;
    int c;
    while (falls.size() < 1 && n < 400) begin
      @(posedge clk7);
      n++;
    end
    if (falls.size() < 1) begin
      chk({tag, "_tmo"}, 0, 1);
      return;
    end
    lv = falls.pop_front();
    c  = fall_cyc.pop_front();
    chk({tag, "_lvl"}, lv, 0);
    chk({tag, "_gap"}, c - last_fall_cyc, RESYNC_GAP);
    last_fall_cyc = c;
  endtask

  task automatic hs(input int low);
    repeat (14) @(posedge clk7);
    #1 cia = 1'b0;
    repeat (low) @(posedge clk7);
    #1 cia = 1'b1;
  endtask

  task automatic expect_acks(input string tag, input int a0, input int delta);
    repeat (8) @(posedge clk7);
    chk(tag, acks - a0, delta);
  endtask

  int a0;

  initial begin
    cia       = 1'b1;
    reset     = 1'b1;
    keystrobe = 1'b0;
    keydat    = 8'h00;
    repeat (3) @(posedge clk7);
    @(negedge clk7);
    chk("rst_kclk", kclk, 1);
    chk("rst_kdat", kdat, 1);
    chk("rst_busy", busy, 0);
    chk("rst_keyack", keyack, 0);
    @(posedge clk7); #1 reset = 1'b0;

    // Power-up sequence
    a0 = acks;
    recv_byte("pu_fd", 8'hFD); hs(3);
    recv_byte("pu_fe", 8'hFE); hs(3);
    expect_acks("pu_noack", a0, 0);
    chk("pu_busy", busy, 0);

    // Key down 0x45
    a0 = acks;
    send_key(8'h45);
    chk("k45_busy", busy, 1);
    recv_byte("k45", 8'h45); hs(3);
    expect_acks("k45_ack", a0, 1);
    chk("k45_idle", busy, 0);

    // Key up 0xC5, with a second keystrobe during the frame that must be dropped
    a0 = acks;
    send_key(8'hC5);
    repeat (30) @(posedge clk7);
    send_key(8'h12);
    recv_byte("kc5", 8'hC5); hs(3);
    expect_acks("kc5_ack", a0, 1);
    repeat (60) @(posedge clk7);
    chk("ignored_strobe_quiet", falls.size(), 0);
    chk("ignored_strobe_busy", busy, 0);

    // A one-cycle glitch is not a handshake
    a0 = acks;
    send_key(8'h33);
    recv_byte("k33", 8'h33);
    repeat (14) @(posedge clk7);
    #1 cia = 1'b0;
    @(posedge clk7); #1 cia = 1'b1;
    expect_acks("glitch_noack", a0, 0);
    hs(2);
    expect_acks("glitch_then_ack", a0, 1);

    // Timeout, two resync bits, then F9 followed by a resend of the last byte
    a0 = acks;
    send_key(8'h45);
    recv_byte("to_k45", 8'h45);
    recv_resync("resync1");
    recv_resync("resync2");
    hs(3);
    recv_byte("to_f9", 8'hF9); hs(3);
    expect_acks("to_f9_noack", a0, 0);
    recv_byte("to_rep45", 8'h45); hs(3);
    expect_acks("to_ack", a0, 1);

    // Reset in the middle of a frame, then a timeout during power-up
    a0 = acks;
    send_key(8'h5A);
    begin
      int n = 0;
      while (falls.size() < 4 && n < 200) begin
        @(posedge clk7);
        n++;
      end
    end
    repeat (2) @(posedge clk7);
    #1 reset = 1'b1;
    @(posedge clk7); #1;
    chk("mid_rst_kclk", kclk, 1);
    chk("mid_rst_kdat", kdat, 1);
    chk("mid_rst_busy", busy, 0);
    reset = 1'b0;
    flush();
    recv_byte("pu2_fd", 8'hFD);
    recv_resync("pu2_resync");
    hs(3);
    recv_byte("pu2_f9", 8'hF9); hs(3);
    recv_byte("pu2_fd_rep", 8'hFD); hs(3);
    recv_byte("pu2_fe", 8'hFE); hs(3);
    expect_acks("pu2_noack", a0, 0);
    send_key(8'h5A);
    recv_byte("k5a", 8'h5A); hs(3);
    expect_acks("k5a_ack", a0, 1);

    // Random key events with random handshake lengths and occasional glitches
    for (int it = 0; it < 6; it++) begin
      logic [7:0] code;
      int low;
      code = 8'($urandom_range(0, 255));
      low  = $urandom_range(2, 5);
      a0   = acks;
      send_key(code);
      recv_byte($sformatf("rnd%0d_%02h", it, code), code);
      if ($urandom_range(0, 1) == 1) begin
        repeat (14) @(posedge clk7);
        #1 cia = 1'b0;
        @(posedge clk7); #1 cia = 1'b1;
      end
      hs(low);
      expect_acks($sformatf("rnd%0d_ack", it), a0, 1);
      chk($sformatf("rnd%0d_busy", it), busy, 0);
    end

    chk("ack_width", ack_wide, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
